// File: rtl/ctrl_rst_seq.sv
// Staged reset sequencer: qualifies PLL lock, releases the control domain and then the
// system core, services button/software system resets and counts lock losses.
//
// state | meaning
// WAIT  | everything in reset, waiting for synced PLL lock
// STAB  | lock seen, counting LOCK_CYCLES of uninterrupted lock
// CREL  | control domain released, system core held for SYS_DELAY
// RUN   | both domains out of reset
// SHOLD | system core pulsed into reset for SYS_HOLD cycles
module ctrl_rst_seq #(
  parameter int LOCK_CYCLES = 1024,
  parameter int SYS_DELAY   = 256,
  parameter int SYS_HOLD    = 64,
  parameter int DEB_CYCLES  = 16384,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       ext_rst_btn,
  input  logic       sw_rst_req,
  output logic       rst_ctrl,
  output logic       rst_sys,
  output logic       rst_done,
  output logic [7:0] lock_lost_cnt
);

  typedef enum logic [2:0] {WAIT, STAB, CREL, RUN, SHOLD} state_t;

  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] SYS_TC  = CW'(SYS_DELAY - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(SYS_HOLD - 1);
  localparam logic [CW-1:0] DEB_TC  = CW'(DEB_CYCLES - 1);

  state_t        state, nxt;
  logic          lk_m, lk_s, bt_m, bt_s, deb;
  logic [CW-1:0] deb_cnt, cnt;
  logic          deb_flip, btn_evt, lost;

  // The event fires on the edge deb flips high, so SHOLD starts on that same edge.
  assign deb_flip = (bt_s != deb) && (deb_cnt == DEB_TC);
  assign btn_evt  = deb_flip && bt_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_m    <= 1'b0;
      lk_s    <= 1'b0;
      bt_m    <= 1'b0;
      bt_s    <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
      bt_m <= ext_rst_btn;
      bt_s <= bt_m;
      if (bt_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        deb     <= bt_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nxt  = state;
    lost = 1'b0;
    case (state)
      WAIT:  if (lk_s) nxt = STAB;
      STAB: begin
        if (!lk_s)                nxt = WAIT;
        else if (cnt == LOCK_TC)  nxt = CREL;
      end
      CREL: begin
        if (!lk_s) begin
          nxt  = WAIT;
          lost = 1'b1;
        end else if (cnt == SYS_TC) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (!lk_s) begin
          nxt  = WAIT;
          lost = 1'b1;
        end else if (sw_rst_req || btn_evt) begin
          nxt = SHOLD;
        end
      end
      SHOLD: begin
        if (!lk_s) begin
          nxt  = WAIT;
          lost = 1'b1;
        end else if (cnt == HOLD_TC) begin
          nxt = RUN;
        end
      end
      default: nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WAIT;
      cnt           <= '0;
      rst_ctrl      <= 1'b1;
      rst_sys       <= 1'b1;
      rst_done      <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state <= nxt;
      if (nxt != state || state == WAIT || state == RUN) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;
      rst_ctrl <= (nxt == WAIT) || (nxt == STAB);
      rst_sys  <= (nxt != RUN);
      rst_done <= (nxt == RUN);
      if (lost && lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

endmodule
